// File: rtl/scan_config_loader.sv
// -----------------------------------------------------------------------------
// scan_config_loader
//
// Upstream configuration controller for the fabric scan chain. Configuration
// words arrive over a valid/ready handshake. Each word is shifted LSB-first into
// the chain, one bit per scan_en cycle. After exactly CHAIN_LEN bits the block
// pulses done for one cycle. Unused upper bits of the final word are dropped.
//
// Ports:
//   clk           rising-edge clock, single domain
//   rst_n         synchronous active-low reset; abandons any load in progress
//   start         begin a load (sampled only while idle)
//   cfg_data      configuration word, bit 0 shifted first
//   cfg_valid     cfg_data is valid
//   cfg_ready     loader accepts a word this cycle
//   scan_en       chain shifts on this edge
//   scan_out      serial bit to the chain's scan_in (0 when scan_en is low)
//   busy          load in progress
//   done          one-cycle pulse after the last bit has been shifted
//   bits_shifted  bits shifted in the current / last load
// -----------------------------------------------------------------------------
module scan_config_loader #(
    parameter int CHAIN_LEN  = 32,
    parameter int WORD_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] cfg_data,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    output logic                  scan_en,
    output logic                  scan_out,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  bits_shifted
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_WORD = 2'd1,
        SHIFT     = 2'd2,
        DONE      = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CHAIN_LEN_C  = CNT_WIDTH'(CHAIN_LEN);
    localparam logic [CNT_WIDTH-1:0] WORD_WIDTH_C = CNT_WIDTH'(WORD_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(1);

    state_t                state_q,        state_d;
    logic [WORD_WIDTH-1:0] buf_q,          buf_d;
    logic [CNT_WIDTH-1:0]  word_left_q,    word_left_d;
    logic [CNT_WIDTH-1:0]  bits_left_q,    bits_left_d;
    logic [CNT_WIDTH-1:0]  bits_shifted_q, bits_shifted_d;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q        <= IDLE;
            buf_q          <= '0;
            word_left_q    <= '0;
            bits_left_q    <= '0;
            bits_shifted_q <= '0;
        end else begin
            state_q        <= state_d;
            buf_q          <= buf_d;
            word_left_q    <= word_left_d;
            bits_left_q    <= bits_left_d;
            bits_shifted_q <= bits_shifted_d;
        end
    end

    // Next-state and datapath logic.
    always_comb begin
        // NOTE: every signal gets a hold-value default first, so no path through
        // the case statement can leave one unassigned and infer a latch.
        state_d        = state_q;
        buf_d          = buf_q;
        word_left_d    = word_left_q;
        bits_left_d    = bits_left_q;
        bits_shifted_d = bits_shifted_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d        = WAIT_WORD;
                    bits_shifted_d = '0;
                    bits_left_d    = CHAIN_LEN_C;
                end
            end
            WAIT_WORD: begin
                if (cfg_valid) begin
                    buf_d       = cfg_data;
                    // The final word may carry fewer useful bits than WORD_WIDTH.
                    word_left_d = (bits_left_q < WORD_WIDTH_C) ? bits_left_q : WORD_WIDTH_C;
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                buf_d          = buf_q >> 1;
                word_left_d    = word_left_q - CNT_ONE;
                bits_left_d    = bits_left_q - CNT_ONE;
                bits_shifted_d = bits_shifted_q + CNT_ONE;
                if (word_left_q == CNT_ONE) begin
                    state_d = (bits_left_q == CNT_ONE) ? DONE : WAIT_WORD;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode from registered state only: no input-to-output path.
    always_comb begin
        cfg_ready    = 1'b0;
        scan_en      = 1'b0;
        scan_out     = 1'b0;
        busy         = (state_q != IDLE);
        done         = 1'b0;
        bits_shifted = bits_shifted_q;

        unique case (state_q)
            IDLE:      ;
            WAIT_WORD: cfg_ready = 1'b1;
            SHIFT: begin
                scan_en  = 1'b1;
                scan_out = buf_q[0];
            end
            DONE:      done = 1'b1;
            default:   ;
        endcase
    end

endmodule
